// File: rtl/pipe_stage_buf.sv
// Elastic v/stall pipeline buffer, DEPTH entries of WIDTH bits, sync flush.
// Define STAGEBUF_BYPASS_EN for zero-latency pass-through when empty.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             stall_o,
  output logic             v_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             byp;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign stall_o = (count == FULL);
  assign count_o = count;

`ifdef STAGEBUF_BYPASS_EN
  assign byp = empty && v_i && !stall_i && !flush_i;
`else
  assign byp = 1'b0;
`endif

  // a bypassed entry is consumed downstream, never stored
  assign push = v_i && !stall_o && !byp;
  assign pop  = !empty && !stall_i;

  always_comb begin
    v_o    = !empty || byp;
    data_o = '0;
    if (!empty)
      data_o = mem[rptr];
    else if (byp)
      data_o = data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else if (flush_i) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push)
        wptr <= nxt(wptr);
      if (pop)
        rptr <= nxt(rptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i)
      mem[wptr] <= data_i;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: vector table, directed corners, random vs queue model.
// Bypass expectations follow STAGEBUF_BYPASS_EN.
module tb_pipe_stage_buf;

  logic       clk;
  logic       rst;
  logic       v;
  logic [7:0] d;
  logic       si;
  logic       fl;
  logic       so;
  logic       vo;
  logic [7:0] dout;
  logic [1:0] cnt;

  logic       v3;
  logic [7:0] d3;
  logic       si3;
  logic       fl3;
  logic       so3;
  logic       vo3;
  logic [7:0] dout3;
  logic [1:0] cnt3;

  int npass;
  int ntot;

`ifdef STAGEBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .v_i(v), .data_i(d),
    .stall_o(so), .v_o(vo), .data_o(dout),
    .stall_i(si), .flush_i(fl), .count_o(cnt)
  );

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .v_i(v3), .data_i(d3),
    .stall_o(so3), .v_o(vo3), .data_o(dout3),
    .stall_i(si3), .flush_i(fl3), .count_o(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       si;
    logic       fl;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
    logic       es;
  } vec_t;

  vec_t tbl[13];

  logic [7:0] q[$];
  logic [7:0] got[$];

  task automatic step3(input logic iv, input logic [7:0] id,
                       input logic isi, input logic ev,
                       input logic [7:0] ed, input logic [1:0] ec);
    v3 = iv; d3 = id; si3 = isi;
    @(negedge clk);
    chk("w3_v", 32'(vo3), 32'(ev));
    chk("w3_d", 32'(dout3), 32'(ed));
    chk("w3_cnt", 32'(cnt3), 32'(ec));
    chk("w3_stall", 32'(so3), 32'(ec == 2'd3));
    @(posedge clk); #1;
  endtask

  initial begin
    logic       mv;
    logic [7:0] md;
    logic       mst;
    logic       mbyp;
    logic       stall_seen;
    npass = 0; ntot = 0;
    v = 0; d = 0; si = 0; fl = 0;
    v3 = 0; d3 = 0; si3 = 0; fl3 = 0;

    // v, d, si, fl, exp v_o, exp data_o, exp count, exp stall
    tbl[0]  = '{1, 8'hA1, 1, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{1, 8'hB2, 1, 0, 1, 8'hA1, 1, 0};
    tbl[2]  = '{1, 8'hC3, 1, 0, 1, 8'hA1, 2, 1};
    tbl[3]  = '{0, 8'h00, 0, 0, 1, 8'hA1, 2, 1};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 8'hB2, 1, 0};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
    tbl[6]  = '{1, 8'h11, 1, 0, 0, 8'h00, 0, 0};
    tbl[7]  = '{1, 8'h22, 1, 0, 1, 8'h11, 1, 0};
    tbl[8]  = '{1, 8'h55, 1, 1, 1, 8'h11, 2, 1};
    tbl[9]  = '{1, 8'h66, 1, 0, 0, 8'h00, 0, 0};
    tbl[10] = '{1, 8'h55, 0, 1, 1, 8'h66, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
    tbl[12] = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0};

    rst = 0;
    #12;
    chk("rst_v", 32'(vo), 0);
    chk("rst_stall", 32'(so), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_d", 32'(dout), 0);
    rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      v = tbl[i].v; d = tbl[i].d; si = tbl[i].si; fl = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("tbl%0d_v", i), 32'(vo), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_d", i), 32'(dout), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_stall", i), 32'(so), 32'(tbl[i].es));
      @(posedge clk); #1;
    end

    // async reset with one entry held
    v = 1; d = 8'hAA; si = 1; fl = 0;
    @(posedge clk); #1;
    v = 0;
    chk("ar_pre_cnt", 32'(cnt), 1);
    @(negedge clk); #1;
    rst = 0;
    #1;
    chk("ar_v", 32'(vo), 0);
    chk("ar_cnt", 32'(cnt), 0);
    chk("ar_d", 32'(dout), 0);
    #1 rst = 1;
    @(posedge clk); #1;
    q.delete();

    for (int i = 0; i < 400; i++) begin
      v  = ($urandom % 4) != 0;
      d  = 8'($urandom);
      si = ($urandom % 3) == 0;
      fl = ($urandom % 25) == 0;
      mst  = (q.size() == 2);
      mbyp = BYP && q.size() == 0 && v && !si && !fl;
      mv   = (q.size() != 0) || mbyp;
      md   = (q.size() != 0) ? q[0] : (mbyp ? d : 8'h00);
      @(negedge clk);
      chk("rnd_v", 32'(vo), 32'(mv));
      chk("rnd_d", 32'(dout), 32'(md));
      chk("rnd_cnt", 32'(cnt), 32'(q.size()));
      chk("rnd_stall", 32'(so), 32'(mst));
      if (fl) q.delete();
      else begin
        if (q.size() != 0 && !si) void'(q.pop_front());
        if (v && !mst && !mbyp) q.push_back(d);
      end
      @(posedge clk); #1;
    end

    v = 0; si = 0; fl = 1;
    @(posedge clk); #1;
    fl = 0;
    stall_seen = 0;
    for (int i = 0; i < 20; i++) begin
      v = (i < 16);
      d = 8'(i);
      @(negedge clk);
      if (vo) got.push_back(dout);
      if (so) stall_seen = 1;
      @(posedge clk); #1;
    end
    v = 0;
    chk("str_n", 32'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("str%0d", i), 32'(got[i]), 32'(i));
    chk("str_stall", 32'(stall_seen), 0);
    chk("str_cnt", 32'(cnt), 0);

    step3(1, 8'd1, 1, 0, 8'd0, 2'd0);
    step3(1, 8'd2, 1, 1, 8'd1, 2'd1);
    step3(1, 8'd3, 1, 1, 8'd1, 2'd2);
    step3(0, 8'd0, 0, 1, 8'd1, 2'd3);
    step3(1, 8'd4, 1, 1, 8'd2, 2'd2);
    step3(0, 8'd0, 0, 1, 8'd2, 2'd3);
    step3(0, 8'd0, 0, 1, 8'd3, 2'd2);
    step3(0, 8'd0, 0, 1, 8'd4, 2'd1);
    step3(0, 8'd0, 0, 0, 8'd0, 2'd0);

`ifdef STAGEBUF_BYPASS_EN
    v = 1; d = 8'h77; si = 0; fl = 0;
    #1;
    chk("byp_v", 32'(vo), 1);
    chk("byp_d", 32'(dout), 32'h77);
    chk("byp_cnt", 32'(cnt), 0);
    @(posedge clk); #1;
    v = 0;
    #1;
    chk("byp_after_cnt", 32'(cnt), 0);
    chk("byp_after_v", 32'(vo), 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic buffer for any inter-stage link of the pipeline (IF→ID, ID→EX, EX→MEM, MEM→WB), using the core's v/stall handshake.
- Generalises the single-entry stage register to DEPTH entries, any payload WIDTH, and a synchronous flush for branch redirect.
- Breaks the combinational stall path: stall_o never depends on stall_i in the same cycle.

Parameters:
- WIDTH, 32, payload bits per entry (≥1).
- DEPTH, 2, number of entries (≥1; need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- v_i  in  1  upstream entry valid.
- data_i  in  WIDTH  upstream payload.
- stall_o  out  1  back-pressure to upstream (buffer full).
- v_o  out  1  head entry valid downstream.
- data_o  out  WIDTH  head payload.
- stall_i  in  1  back-pressure from downstream.
- flush_i  in  1  synchronous discard of all contents.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): count=0, read pointer=0, write pointer=0. Outputs: v_o=0, stall_o=0, count_o=0, data_o=0. Storage contents are don't-care.
- Push occurs when v_i && !stall_o. Pop occurs when v_o && !stall_i.
- stall_o = (count == DEPTH). It is a decode of registered count only.
- v_o = (count != 0). data_o = entry at read pointer. data_o is driven 0 when empty.
- Latency: an entry pushed at edge N is visible on v_o/data_o after edge N (1 cycle). Order is strict FIFO.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count=DEPTH): push blocked by stall_o. A pop that cycle frees one slot. stall_o drops after that edge, not in the same cycle.
- Empty: v_o=0. stall_i is ignored.
- Pointer wrap: each pointer increments modulo DEPTH (DEPTH-1 → 0). Non-power-of-two DEPTH must wrap correctly.
- flush_i=1 at an edge:
  - count, read pointer and write pointer reset to 0.
  - Any push or pop in that cycle is discarded.
  - flush_i has priority over push and pop.
- v_i=0: data_i is ignored.
- Deasserting v_i while stall_o is high is permitted; nothing is pushed.
- Reset mid-operation: contents are lost immediately and outputs take their reset values asynchronously.
- No combinational path from any input to stall_o. The DEPTH≥2 default gives full throughput (one transfer per cycle) under steady flow.

Optional Feature:
- Macro STAGEBUF_BYPASS_EN.
- Defined: when count=0 && v_i && !stall_i && !flush_i, the entry passes straight through in the same cycle:
  - v_o=1 and data_o=data_i combinationally.
  - The entry is consumed by downstream and not written to storage; count stays 0.
  - This gives 0-cycle latency when empty and adds a comb path v_i/data_i → v_o/data_o.
- Undefined: no bypass; latency is always 1 cycle, as above.

Test Plan:
- Reset and fill: rst low then high, DEPTH=2, stall_i=1, push 0xA1 then 0xB2 → count_o=2, stall_o=1, v_o=1, data_o=0xA1. A third v_i=1 with 0xC3 is not accepted.
- Drain order: from full, stall_i=0 → data_o=0xA1 then 0xB2 on consecutive cycles, then v_o=0, count_o=0. stall_o drops the cycle after the first pop.
- Streaming: v_i=1 every cycle with 0x00..0x0F, stall_i=0 → 16 outputs in order, one per cycle after a 1-cycle fill, stall_o never set.
- Wrap, DEPTH=3: push 1,2,3, pop 1, push 4, pop all → outputs 2,3,4 and count_o returns to 0.
- Flush: count_o=2 with a simultaneous push of 0x55 and flush_i=1 → next cycle count_o=0, v_o=0, and 0x55 never appears at data_o.
- Async reset mid-stream: drop rst between edges with count_o=1 → v_o=0 and count_o=0 immediately, before the next clk edge.
- With STAGEBUF_BYPASS_EN, when empty: v_i=1, data_i=0x77, stall_i=0 → v_o=1, data_o=0x77 in the same cycle, count_o stays 0.
